upsampler: RTL
==============

UPSAMPLER -- requirements
Module: upsampler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits for input and output.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  synchronous active-high reset, sampled on rising CLK.
REQ-004 SHALL have port in_valid  input  1  upstream sample on a is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a this cycle; transfer when in_valid && in_ready.
REQ-006 SHALL have port a  input  WIDTH  input sample, unsigned.
REQ-007 SHALL have port out_valid  output  1  out holds a valid sample.
REQ-008 SHALL have port out_ready  input  1  downstream accepts out; transfer when out_valid && out_ready.
REQ-009 SHALL have port out  output  WIDTH  output sample, unsigned, registered.

Function
REQ-010 SHALL upsample by 2 using linear interpolation: each accepted sample x[n] produces exactly two outputs, in order: mid = (x[n-1] + x[n]) >> 1, then x[n].
REQ-011 SHALL compute mid with a WIDTH+1-bit sum; result never overflows (255+255 -> 255 at WIDTH=8).
REQ-012 SHALL hold x[n-1] in a prev register, updated to x[n] on each input transfer; prev = 0 after reset.
REQ-013 SHALL implement FSM states EMPTY, MID, SAMPLE: EMPTY -> MID on input transfer; MID -> SAMPLE on output transfer; SAMPLE -> EMPTY on output transfer without input transfer; SAMPLE -> MID on simultaneous output and input transfer.
REQ-014 SHALL drive out_valid = 1 exactly in states MID and SAMPLE.
REQ-015 SHALL drive in_ready = 1 in EMPTY, and in SAMPLE when out_ready = 1; in_ready = 0 in MID; in_ready SHALL be combinational from state and out_ready only (never from in_valid).
REQ-016 SHALL register out: mid loaded on entry to MID, x[n] loaded on entry to SAMPLE; first output valid one cycle after the input transfer.
REQ-017 SHALL hold out and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-018 SHALL sustain one input every 2 cycles and one output every cycle with in_valid and out_ready held high.
REQ-019 SHALL ignore a while no input transfer occurs; in_valid with in_ready = 0 has no effect.

Reset
REQ-020 SHALL on RST = 1 at a rising edge set state EMPTY, prev = 0, out = 0, out_valid = 0, regardless of any transfer that cycle.
REQ-021 SHALL drop pending outputs when reset occurs mid-operation (MID or SAMPLE); the first sample after reset interpolates against prev = 0.
REQ-022 SHALL present in_ready = 1 in the first cycle after reset is released.

Configuration
REQ-023 SHALL, with macro UPSAMPLER_ROUND_EN defined, compute mid = (x[n-1] + x[n] + 1) >> 1 (round half up, WIDTH+1-bit sum, still no overflow).
REQ-024 SHALL, without UPSAMPLER_ROUND_EN, compute mid = (x[n-1] + x[n]) >> 1 (truncate); all other behaviour identical.

Verification
REQ-025 SHALL cover reset then inputs 10, 20, 30 with out_ready = 1 -> outputs 5, 10, 15, 20, 25, 30; in_ready pattern 1,0,1,0,1.
REQ-026 SHALL cover inputs 255, 255 -> outputs 127, 255, 255, 255 (truncate), 128, 255, 255, 255 (UPSAMPLER_ROUND_EN).
REQ-027 SHALL cover back-pressure: input 100 after reset, out_ready = 0 for 5 cycles -> out = 50, out_valid = 1 stable, in_ready = 0; then out_ready = 1 -> 50, 100 delivered once each.
REQ-028 SHALL cover simultaneous events: in SAMPLE with out_ready = 1 and in_valid = 1 carrying 40 after prev 20 -> 20 transferred and 40 accepted same cycle, next out = 30 in MID.
REQ-029 SHALL cover reset in MID after input 80 -> out_valid = 0 next cycle, 80 never output; next input 8 -> outputs 4, 8.

Source files
------------

// File: rtl/upsampler.sv
// 2x linear-interpolating upsampler with valid/ready handshakes on both sides.
// Define UPSAMPLER_ROUND_EN to round the interpolated midpoint half-up instead of truncating.
module upsampler #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    MID    = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] out_r;
  logic             in_xfer_s;

  // Midpoint uses a WIDTH+1 bit sum so the carry is kept before halving.
  function automatic logic [WIDTH-1:0] interp(input logic [WIDTH-1:0] p,
                                              input logic [WIDTH-1:0] x);
    logic [WIDTH:0] sum;
`ifdef UPSAMPLER_ROUND_EN
    sum = {1'b0, p} + {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
`else
    sum = {1'b0, p} + {1'b0, x};
`endif
    return sum[WIDTH:1];
  endfunction

  // Next-state and handshake decode; in_ready depends on state and out_ready only.
  always_comb begin
    state_nxt_s = state_r;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state_r)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt_s = MID;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      MID: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt_s = SAMPLE;
        end else begin
          state_nxt_s = MID;
        end
      end
      SAMPLE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_nxt_s = MID;
          end else begin
            state_nxt_s = EMPTY;
          end
        end else begin
          state_nxt_s = SAMPLE;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  assign in_xfer_s = in_valid & in_ready;
  assign out       = out_r;

  // State, history sample and output register; reset wins over any transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= EMPTY;
      prev_r  <= {WIDTH{1'b0}};
      out_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (in_xfer_s) begin
        prev_r <= a;
        out_r  <= interp(prev_r, a);
      end else if ((state_r == MID) && out_ready) begin
        // prev_r already holds x[n] once the midpoint has been presented
        out_r  <= prev_r;
      end else begin
        out_r  <= out_r;
      end
    end
  end

endmodule
